// File: rtl/uart_cmd_assembler.sv
// Pairs bytes from a UART receiver into 16-bit commands (high byte first).
// An inter-byte timeout resyncs after a lost byte, and a sticky overrun flag is kept.
module uart_cmd_assembler #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cmd_overrun,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [7:0]       r_hi_byte;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic [15:0]      r_cmd;
  logic             r_cmd_rdy;
  logic             r_cmd_overrun;
  logic             r_timeout_err;
  logic             w_ack;
  logic             w_capture_hi;
  logic             w_complete;
  logic             w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    w_state_nx   = r_state;
    w_ack        = 1'b0;
    w_capture_hi = 1'b0;
    w_complete   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_rdy) begin
          w_ack        = 1'b1;
          w_capture_hi = 1'b1;
          w_state_nx   = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        // A byte in the final timeout cycle still wins over the timeout.
        if (rx_rdy) begin
          w_ack      = 1'b1;
          w_complete = 1'b1;
          w_state_nx = IDLE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_timeout  = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Ack is Mealy so the receiver drops rdy on the very next edge.
  assign clr_rx_rdy = w_ack & ~rst;

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi_byte     <= 8'h00;
      r_tmo_cnt     <= '0;
      r_cmd         <= 16'h0000;
      r_cmd_rdy     <= 1'b0;
      r_cmd_overrun <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;

      if (w_capture_hi) begin
        r_hi_byte <= rx_data;
        r_tmo_cnt <= '0;
      end else if (r_state == WAIT_LOW && !rx_rdy && !w_timeout) begin
        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
      end

      if (w_complete) r_cmd <= {r_hi_byte, rx_data};

      if (w_complete)       r_cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;

      if (w_complete && r_cmd_rdy && !clr_cmd_rdy) r_cmd_overrun <= 1'b1;
      else if (clr_cmd_rdy)                        r_cmd_overrun <= 1'b0;
    end
  end

  assign cmd         = r_cmd;
  assign cmd_rdy     = r_cmd_rdy;
  assign cmd_overrun = r_cmd_overrun;
  assign timeout_err = r_timeout_err;

endmodule
